// File: rtl/led_chaser.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// led_chaser
//
// LED chaser pattern generator driven by two push-buttons. It is the top level
// that sits between the board button/switch pins and the LED bank.
//
// btn_run starts, pauses and resumes the chase. btn_mode steps through four
// patterns. Both buttons are asynchronous to clk. Each one passes through a
// 2-flop synchroniser, an optional debouncer and a rising-edge detector, which
// together produce one single-cycle pulse per press.
//
// Optional build macro: LED_CHASER_DEBOUNCE_EN
//   defined   : each synchronised button must hold a new level for DEB_CYCLES
//               consecutive cycles before the level is accepted.
//   undefined : no debounce logic. The edge detector takes the synchroniser
//               output directly, so a press acts on the 3rd clk edge.
//
// Parameters
//   LED_N      : number of LEDs (>= 2)
//   TICK_DIV   : clock cycles per pattern step at speed = 0 (>= 8)
//   DEB_CYCLES : debounce stability window in cycles (>= 1)
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   btn_run  in   raw run/pause button, active-high, asynchronous
//   btn_mode in   raw mode button, active-high, asynchronous
//   speed    in   [1:0] step period = TICK_DIV >> speed
//   led      out  [LED_N-1:0] LED drive, 1 = lit
//   running  out  high while the chaser is in RUN
//   mode     out  [1:0] pattern: 0 rotL, 1 rotR, 2 bounce, 3 fill
// -----------------------------------------------------------------------------
module led_chaser #(
   parameter int LED_N      = 8,
   parameter int TICK_DIV   = 100000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_run,
   input  logic             btn_mode,
   input  logic [1:0]       speed,
   output logic [LED_N-1:0] led,
   output logic             running,
   output logic [1:0]       mode
);

   localparam int CNT_W = $clog2(TICK_DIV);

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Reject parameter values the datapath cannot represent.
   if (LED_N < 2 || TICK_DIV < 8 || DEB_CYCLES < 1) begin : g_param_check
      $error("led_chaser: illegal parameter value");
   end

   // Seed pattern loaded when a mode is entered or the chase starts.
   function automatic logic [LED_N-1:0] seed_fn(input logic [1:0] m);
      logic [LED_N-1:0] s;
      s = '0;
      case (m)
         2'd0, 2'd2: s[0]       = 1'b1;
         2'd1:       s[LED_N-1] = 1'b1;
         default:    s          = '0;
      endcase
      return s;
   endfunction

   // One pattern step. Returns {next_direction, next_led}.
   function automatic logic [LED_N:0] step_fn(input logic [1:0]       m,
                                              input logic [LED_N-1:0] l,
                                              input logic             d);
      logic [LED_N-1:0] nl;
      logic             nd;
      nl = l;
      nd = d;
      case (m)
         2'd0: nl = {l[LED_N-2:0], l[LED_N-1]};
         2'd1: nl = {l[0], l[LED_N-1:1]};
         2'd2: begin
            // The direction flips on the step that lands on an end bit, so
            // each end bit stays lit for exactly one step.
            if (d == DIR_LEFT) begin
               nl = l << 1;
               if (nl[LED_N-1]) nd = DIR_RIGHT;
            end else begin
               nl = l >> 1;
               if (nl[0]) nd = DIR_LEFT;
            end
         end
         default: nl = (&l) ? '0 : {l[LED_N-2:0], 1'b1};
      endcase
      return {nd, nl};
   endfunction

   // ---------------------------------------------------------------- stage p0/p1
   // Two-flop synchronisers. Bit 0 is run, bit 1 is mode.
   logic [1:0] btn_raw;
   logic [1:0] btn_sync_p0;
   logic [1:0] btn_sync_p1;

   assign btn_raw = {btn_mode, btn_run};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sync_p0 <= '0;
         btn_sync_p1 <= '0;
      end else begin
         btn_sync_p0 <= btn_raw;
         btn_sync_p1 <= btn_sync_p0;
      end
   end

   // ---------------------------------------------------------------- stage p2
   // Accepted (debounced) button level.
   logic [1:0] btn_lvl_p2;

`ifdef LED_CHASER_DEBOUNCE_EN
   localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [DEB_W-1:0] deb_cnt [2];

   // The counter restarts whenever the input matches the accepted level, so
   // only an unbroken run of DEB_CYCLES differing samples changes the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_lvl_p2 <= '0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (btn_sync_p1[i] == btn_lvl_p2[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               btn_lvl_p2[i] <= btn_sync_p1[i];
               deb_cnt[i]    <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end
`else
   assign btn_lvl_p2 = btn_sync_p1;
`endif

   // ---------------------------------------------------------------- stage p3
   // Rising-edge detection: one pulse per accepted press.
   logic [1:0] btn_prev_p3;
   logic       run_p;
   logic       mode_p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev_p3 <= '0;
      end else begin
         btn_prev_p3 <= btn_lvl_p2;
      end
   end

   assign run_p  = btn_lvl_p2[0] & ~btn_prev_p3[0];
   assign mode_p = btn_lvl_p2[1] & ~btn_prev_p3[1];

   // ---------------------------------------------------------------- chaser core
   state_t           state;
   state_t           state_n;
   logic [LED_N-1:0] led_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             dir;
   logic             dir_n;
   logic [1:0]       mode_n;
   logic [31:0]      period;
   logic [CNT_W-1:0] tick_lim;

   // A >= compare against the live limit means that a speed increase
   // mid-count steps on the next cycle and never wraps through the full range.
   assign period   = 32'(TICK_DIV) >> speed;
   assign tick_lim = CNT_W'(period - 32'd1);

   always_comb begin
      state_n = state;
      led_n   = led;
      cnt_n   = cnt;
      dir_n   = dir;
      mode_n  = mode;

      // A mode change is applied first, so a simultaneous run press from IDLE
      // starts in the new mode with its seed.
      if (mode_p) begin
         mode_n = mode + 2'd1;
         cnt_n  = '0;
         dir_n  = DIR_LEFT;
         if (state != IDLE) led_n = seed_fn(mode_n);
      end

      if (run_p) begin
         case (state)
            IDLE: begin
               state_n = RUN;
               led_n   = seed_fn(mode_n);
               cnt_n   = '0;
               dir_n   = DIR_LEFT;
            end
            RUN:     state_n = PAUSE;
            PAUSE:   state_n = RUN;
            default: state_n = IDLE;
         endcase
      end else if (!mode_p && state == RUN) begin
         if (cnt >= tick_lim) begin
            cnt_n          = '0;
            {dir_n, led_n} = step_fn(mode, led, dir);
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         led     <= '0;
         cnt     <= '0;
         dir     <= DIR_LEFT;
         mode    <= 2'd0;
         running <= 1'b0;
      end else begin
         state   <= state_n;
         led     <= led_n;
         cnt     <= cnt_n;
         dir     <= dir_n;
         mode    <= mode_n;
         // Registered from the next state so it always equals (state == RUN).
         running <= (state_n == RUN);
      end
   end

endmodule

// File: tb/tb_led_chaser.sv
`timescale 1ns/1ps
module tb_led_chaser;

   localparam int LED_N      = 8;
   localparam int TICK_DIV   = 8;
   localparam int DEB_CYCLES = 4;
`ifdef LED_CHASER_DEBOUNCE_EN
   localparam int LAT = 3 + DEB_CYCLES;
`else
   localparam int LAT = 3;
`endif
   localparam int HOLD = 10;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic             btn_run  = 1'b0;
   logic             btn_mode = 1'b0;
   logic [1:0]       speed    = 2'd0;
   logic [LED_N-1:0] led;
   logic             running;
   logic [1:0]       mode;

   led_chaser #(
      .LED_N      (LED_N),
      .TICK_DIV   (TICK_DIV),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_run  (btn_run),
      .btn_mode (btn_mode),
      .speed    (speed),
      .led      (led),
      .running  (running),
      .mode     (mode)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  led;
      logic        run;
      logic [1:0]  mode;
   } exp_t;

   exp_t  q_exp[$];
   string q_name[$];
   int    n_vec  = 0;
   int    n_miss = 0;
   int    run_rel  = 0;
   int    mode_rel = 0;

   logic [7:0] rot_tab  [9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] bnc_tab  [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
   logic [7:0] fill_tab [11] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                 8'hFF, 8'h00, 8'h01};

   task automatic expect_at(input int c, input logic [7:0] l, input logic r,
                            input logic [1:0] m, input string nm);
      exp_t e;
      e.cyc  = c;
      e.led  = l;
      e.run  = r;
      e.mode = m;
      q_exp.push_back(e);
      q_name.push_back(nm);
   endtask

   // Advance to just after edge n, releasing held buttons on schedule.
   task automatic go_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
         if (btn_run  && cyc >= run_rel)  btn_run  = 1'b0;
         if (btn_mode && cyc >= mode_rel) btn_mode = 1'b0;
      end
   endtask

   // Monitor: compares every expectation whose cycle has arrived.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         while (q_exp.size() > 0 && int'(q_exp[0].cyc) <= cyc) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_vec++;
            if (int'(e.cyc) < cyc) begin
               n_miss++;
               $display("FAIL %s: check for cycle %0d reached late at cycle %0d", nm, e.cyc, cyc);
            end else if (led !== e.led || running !== e.run || mode !== e.mode) begin
               n_miss++;
               $display("FAIL %s @cyc %0d: got led=%h running=%b mode=%0d, expected led=%h running=%b mode=%0d",
                        nm, cyc, led, running, mode, e.led, e.run, e.mode);
            end
         end
      end
   end

   initial begin
      int t, e0, s, a, b, m1, m2, m3, r, t2, e2, r2, t3, e3;

      // Reset state
      expect_at(1, 8'h00, 1'b0, 2'd0, "reset_hold");
      expect_at(5, 8'h00, 1'b0, 2'd0, "idle_after_reset");
      go_to(3);
      rst = 1'b0;
      go_to(6);

      // Start in mode 0, rotate left every 8 cycles
      t  = cyc;
      e0 = t + LAT;
      expect_at(e0, 8'h01, 1'b1, 2'd0, "run_seed");
      for (int j = 1; j <= 8; j++) begin
         expect_at(e0 + 8*j - 1, rot_tab[j-1], 1'b1, 2'd0, "rotl_hold");
         expect_at(e0 + 8*j,     rot_tab[j],   1'b1, 2'd0, "rotl_step");
      end
      btn_run = 1'b1;
      run_rel = cyc + HOLD;
      s = e0 + 64;
      go_to(s + 1);

      // Pause with 4 counts elapsed, resume 55 cycles later
      a = s + 13;
      b = a + 55;
      expect_at(a,      8'h02, 1'b0, 2'd0, "pause");
      expect_at(a + 25, 8'h02, 1'b0, 2'd0, "pause_frozen");
      expect_at(b - 1,  8'h02, 1'b0, 2'd0, "pause_end");
      expect_at(b,      8'h02, 1'b1, 2'd0, "resume_no_reload");
      expect_at(b + 3,  8'h02, 1'b1, 2'd0, "resume_remaining");
      expect_at(b + 4,  8'h04, 1'b1, 2'd0, "resume_step");
      expect_at(b + 12, 8'h08, 1'b1, 2'd0, "resume_next");
      go_to(a - LAT);
      btn_run = 1'b1;
      run_rel = cyc + HOLD;
      go_to(b - LAT);
      btn_run = 1'b1;
      run_rel = cyc + HOLD;

      // Two mode presses while running: rotR then bounce
      m1 = b + 16;
      m2 = m1 + 35;
      expect_at(m1,     8'h80, 1'b1, 2'd1, "mode1_seed");
      expect_at(m1 + 7, 8'h80, 1'b1, 2'd1, "mode1_hold");
      expect_at(m1 + 8, 8'h40, 1'b1, 2'd1, "rotr_step");
      expect_at(m2,     8'h01, 1'b1, 2'd2, "mode2_seed");
      for (int j = 1; j <= 15; j++) begin
         if (j == 8)  expect_at(m2 + 63,  8'h80, 1'b1, 2'd2, "bounce_top_once");
         if (j == 15) expect_at(m2 + 119, 8'h01, 1'b1, 2'd2, "bounce_bottom_once");
         expect_at(m2 + 8*j, bnc_tab[j], 1'b1, 2'd2, "bounce");
      end
      go_to(m1 - LAT);
      btn_mode = 1'b1;
      mode_rel = cyc + HOLD;
      go_to(m2 - LAT);
      btn_mode = 1'b1;
      mode_rel = cyc + HOLD;

      // Mode 3, then speed 0 -> 3 when cnt = 5
      m3 = m2 + 124;
      expect_at(m3,     8'h00, 1'b1, 2'd3, "mode3_seed");
      expect_at(m3 + 5, 8'h00, 1'b1, 2'd3, "fill_wait");
      for (int i = 0; i < 10; i++)
         expect_at(m3 + 6 + i, fill_tab[i+1], 1'b1, 2'd3, "fill_fast");
      go_to(m3 - LAT);
      btn_mode = 1'b1;
      mode_rel = cyc + HOLD;
      go_to(m3 + 5);
      speed = 2'd3;

      // 1 ns asynchronous reset with no clock edge inside it
      r = m3 + 20;
      expect_at(r - 1, 8'h1F, 1'b1, 2'd3, "pre_async_rst");
      expect_at(r,     8'h00, 1'b0, 2'd0, "async_rst");
      expect_at(r + 2, 8'h00, 1'b0, 2'd0, "idle_after_async");
      go_to(r);
      #3.5;
      rst = 1'b1;
      #1;
      rst   = 1'b0;
      speed = 2'd0;
      go_to(r + 3);

`ifdef LED_CHASER_DEBOUNCE_EN
      // 3-cycle glitch on btn_run must be ignored
      t = cyc;
      expect_at(t + 10, 8'h00, 1'b0, 2'd0, "glitch_ignored");
      btn_run = 1'b1;
      run_rel = t + 3;
      go_to(t + 25);
`endif

      // Restart after reset: seed 0x01, single pulse for a long press
      t2 = cyc;
      e2 = t2 + LAT;
      expect_at(e2,      8'h01, 1'b1, 2'd0, "restart_seed");
      expect_at(e2 + 8,  8'h02, 1'b1, 2'd0, "restart_step");
      expect_at(e2 + 30, 8'h08, 1'b1, 2'd0, "single_pulse");
      btn_run = 1'b1;
      run_rel = cyc + HOLD;
      go_to(e2 + 31);

      // Back to IDLE, then run and mode pressed together
      r2 = cyc;
      expect_at(r2 + 1, 8'h00, 1'b0, 2'd0, "rst_again");
      rst = 1'b1;
      go_to(r2 + 2);
      rst = 1'b0;
      go_to(r2 + 4);
      t3 = cyc;
      e3 = t3 + LAT;
      expect_at(e3,     8'h80, 1'b1, 2'd1, "both_start");
      expect_at(e3 + 8, 8'h40, 1'b1, 2'd1, "both_step");
      btn_run  = 1'b1;
      btn_mode = 1'b1;
      run_rel  = cyc + HOLD;
      mode_rel = cyc + HOLD;
      go_to(e3 + 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
